// File: rtl/dmem_arbiter_if.sv
// Bundle of port C, port E and memory-side signals for the data-memory arbiter.
// slave is the arbiter view; master is the environment (requesters plus memory).
interface dmem_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              c_req;
   logic              c_we;
   logic [ADDR_W-1:0] c_addr;
   logic [DATA_W-1:0] c_wdata;
   logic              c_gnt;
   logic              c_rvalid;
   logic [DATA_W-1:0] c_rdata;

   logic              e_req;
   logic              e_we;
   logic [ADDR_W-1:0] e_addr;
   logic [DATA_W-1:0] e_wdata;
   logic              e_gnt;
   logic              e_rvalid;
   logic [DATA_W-1:0] e_rdata;

   logic              mem_w_en;
   logic              mem_r_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] mem_dout;

   modport slave (
      input  c_req, c_we, c_addr, c_wdata, e_req, e_we, e_addr, e_wdata, mem_dout,
      output c_gnt, c_rvalid, c_rdata, e_gnt, e_rvalid, e_rdata,
      output mem_w_en, mem_r_en, mem_addr, mem_din
   );

   modport master (
      output c_req, c_we, c_addr, c_wdata, e_req, e_we, e_addr, e_wdata, mem_dout,
      input  c_gnt, c_rvalid, c_rdata, e_gnt, e_rvalid, e_rdata,
      input  mem_w_en, mem_r_en, mem_addr, mem_din
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port (core C, external E) arbiter onto a single-port data memory with fixed read latency.
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed C priority.
module dmem_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RD_LAT = 1
) (
   input logic           clk,
   input logic           rst_n,
   dmem_arbiter_if.slave bus
);

   typedef enum logic [0:0] {StIdle, StRdWait} state_e;

   state_e            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              owner_q, owner_d;  // 1 = port E owns the outstanding read
   logic              w_en_q, w_en_d;
   logic              r_en_q, r_en_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic              c_rvalid_q, c_rvalid_d;
   logic              e_rvalid_q, e_rvalid_d;
   logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
   logic [DATA_W-1:0] e_rdata_q, e_rdata_d;

   logic              c_win;
   logic              c_gnt, e_gnt, accept;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

`ifdef DMEM_ARB_RR_EN
   logic last_e_q, last_e_d;  // 1 = port E won the most recent acceptance

   assign c_win = bus.c_req && (!bus.e_req || last_e_q);

   always_comb begin
      last_e_d = last_e_q;
      if (accept) last_e_d = e_gnt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_e_q <= 1'b1;
      else        last_e_q <= last_e_d;
   end
`else
   assign c_win = bus.c_req;
`endif

   assign c_gnt     = rst_n && (state_q == StIdle) && c_win;
   assign e_gnt     = rst_n && (state_q == StIdle) && bus.e_req && !c_win;
   assign accept    = c_gnt || e_gnt;
   assign sel_we    = c_gnt ? bus.c_we    : bus.e_we;
   assign sel_addr  = c_gnt ? bus.c_addr  : bus.e_addr;
   assign sel_wdata = c_gnt ? bus.c_wdata : bus.e_wdata;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      owner_d    = owner_q;
      w_en_d     = 1'b0;
      r_en_d     = 1'b0;
      addr_d     = addr_q;
      din_d      = din_q;
      c_rvalid_d = 1'b0;
      e_rvalid_d = 1'b0;
      c_rdata_d  = c_rdata_q;
      e_rdata_d  = e_rdata_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               addr_d = sel_addr;
               din_d  = sel_wdata;
               if (sel_we) begin
                  w_en_d = 1'b1;
               end else begin
                  r_en_d  = 1'b1;
                  state_d = StRdWait;
                  cnt_d   = 3'(RD_LAT);
                  owner_d = e_gnt;
               end
            end
         end
         StRdWait: begin
            // Latency counts from the edge that ends the mem_r_en cycle.
            if (!r_en_q) begin
               if (cnt_q == 3'd1) begin
                  state_d = StIdle;
                  if (owner_q) begin
                     e_rdata_d  = bus.mem_dout;
                     e_rvalid_d = 1'b1;
                  end else begin
                     c_rdata_d  = bus.mem_dout;
                     c_rvalid_d = 1'b1;
                  end
               end else begin
                  cnt_d = 3'(cnt_q - 3'd1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= 3'd0;
         owner_q    <= 1'b0;
         w_en_q     <= 1'b0;
         r_en_q     <= 1'b0;
         addr_q     <= '0;
         din_q      <= '0;
         c_rvalid_q <= 1'b0;
         e_rvalid_q <= 1'b0;
         c_rdata_q  <= '0;
         e_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         owner_q    <= owner_d;
         w_en_q     <= w_en_d;
         r_en_q     <= r_en_d;
         addr_q     <= addr_d;
         din_q      <= din_d;
         c_rvalid_q <= c_rvalid_d;
         e_rvalid_q <= e_rvalid_d;
         c_rdata_q  <= c_rdata_d;
         e_rdata_q  <= e_rdata_d;
      end
   end

   assign bus.c_gnt    = c_gnt;
   assign bus.e_gnt    = e_gnt;
   assign bus.c_rvalid = c_rvalid_q;
   assign bus.e_rvalid = e_rvalid_q;
   assign bus.c_rdata  = c_rdata_q;
   assign bus.e_rdata  = e_rdata_q;
   assign bus.mem_w_en = w_en_q;
   assign bus.mem_r_en = r_en_q;
   assign bus.mem_addr = addr_q;
   assign bus.mem_din  = din_q;

endmodule
